// File: rtl/square_pkg.sv
`default_nettype none
// ==========================================================================
// square_pkg : state encoding and default width for the iterative squarer
// Revision   : 1.0
// ==========================================================================
package square_pkg;

  localparam int DEFAULT_W = 8;

  // 2'b10 is unused and falls back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/square_ctrl.sv
`default_nettype none
// ==========================================================================
// square_ctrl : go/done sequencing FSM for the odd-accumulation squarer
// Revision    : 1.0
// ==========================================================================
module square_ctrl
  import square_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic cnt_zero,
  output logic ld,
  output logic step,
  output logic done,
  output logic busy
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // done rises on the same edge that enters DONE, so it is a clean one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == CALC) && cnt_zero;
    end
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          ld        = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt_zero) begin
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: rtl/square_seq.sv
`default_nettype none
// ==========================================================================
// square_seq : iterative squarer, sq = a*a via 1+3+5+... one add per clock
// Revision   : 1.0
// ==========================================================================
module square_seq
  import square_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [W-1:0]   a,
  output logic [2*W-1:0] sq,
  output logic           done,
  output logic           busy
);

  logic [W-1:0] cnt;
  logic [W:0]   odd;
  logic         cnt_zero;
  logic         ld;
  logic         step;

  assign cnt_zero = (cnt == '0);

  square_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .cnt_zero (cnt_zero),
    .ld       (ld),
    .step     (step),
    .done     (done),
    .busy     (busy)
  );

  // odd peaks at 2a+1 and sq at (2^W-1)^2, so neither register can overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      odd <= (W+1)'(1);
      sq  <= '0;
    end else if (ld) begin
      cnt <= a;
      odd <= (W+1)'(1);
      sq  <= '0;
    end else if (step) begin
      cnt <= cnt - W'(1);
      odd <= odd + (W+1)'(2);
      sq  <= sq + (2*W)'(odd);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_square_seq.sv
`default_nettype none
// ==========================================================================
// tb_square_seq : directed stimulus, cycle-level reference model and checks
// Revision      : 1.0
// ==========================================================================
module tb_square_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           go = 1'b0;
  logic [W-1:0]   a = '0;
  logic [2*W-1:0] sq;
  logic           done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  square_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .a     (a),
    .sq    (sq),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges counted from the accepting edge E0.
  // After Ek (k<=a) the result is k*k, done is high only after E(a+1),
  // and the unit is free again after E(a+2).
  bit      m_active = 1'b0;
  int      m_t = 0;
  int      m_a = 0;
  longint  m_sq = 0;
  bit      m_done = 1'b0;
  bit      m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_sq     = 0;
      m_done   = 1'b0;
      m_busy   = 1'b0;
    end else if (!m_active) begin
      if (go) begin
        m_active = 1'b1;
        m_t      = 0;
        m_a      = int'(a);
        m_sq     = 0;
        m_busy   = 1'b1;
      end
    end else begin
      m_t++;
      if (m_t <= m_a) m_sq = longint'(m_t) * longint'(m_t);
      m_done = (m_t == m_a + 1);
      if (m_t == m_a + 2) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_sq", sq, m_sq);
    check("model_done", done, m_done);
    check("model_busy", busy, m_busy);
  end

  task automatic start(input logic [W-1:0] v);
    @(negedge clk);
    go = 1'b1;
    a  = v;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Counts falling edges until done is seen; n is the edge index after E0.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  int exp5 [5] = '{1, 4, 9, 16, 25};
  int n;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_sq", sq, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    // a = 0
    start(8'd0);
    check("a0_busy_e0", busy, 1);
    @(negedge clk);
    check("a0_done_e1", done, 1);
    check("a0_sq", sq, 0);
    @(negedge clk);
    check("a0_busy_e2", busy, 0);
    check("a0_done_e2", done, 0);

    // a = 5: square after every accumulation edge
    start(8'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("a5_sq_step", sq, exp5[k]);
      check("a5_done_early", done, 0);
    end
    @(negedge clk);
    check("a5_done_e6", done, 1);
    check("a5_sq_final", sq, 25);
    repeat (10) begin
      @(negedge clk);
      check("a5_sq_hold", sq, 25);
    end

    // a = 255: full-range latency and result
    start(8'd255);
    wait_done(400, n);
    check("a255_latency", n, 256);
    check("a255_sq", sq, 16'hFE01);
    @(negedge clk);
    check("a255_done_width", done, 0);

    // go held high, a = 3 then 7
    @(negedge clk);
    go = 1'b1;
    a  = 8'd3;
    @(negedge clk);
    wait_done(20, n);
    check("held_lat3", n, 4);
    check("held_sq9", sq, 9);
    a = 8'd7;
    @(negedge clk);
    check("held_busy_e5", busy, 0);
    check("held_done_e5", done, 0);
    @(negedge clk);
    check("held_busy_e6", busy, 1);
    check("held_sq_clear", sq, 0);
    wait_done(20, n);
    check("held_lat7", n, 8);
    check("held_sq49", sq, 49);
    go = 1'b0;
    repeat (3) @(negedge clk);

    // go and a changes ignored while busy
    start(8'd10);
    repeat (3) @(negedge clk);
    a  = 8'd200;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(40, n);
    check("busy_ignore_sq", sq, 100);
    repeat (3) @(negedge clk);

    // reset mid-calculation
    start(8'd10);
    repeat (4) @(negedge clk);
    check("abort_sq_e4", sq, 16);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sq", sq, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    start(8'd3);
    wait_done(20, n);
    check("after_reset_sq", sq, 9);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
